nina_boot_sequencer: RTL and testbench

Sequences the NINA ESP32 reset (EN) and strap (GPIO0) lines so the module enters either normal run or UART download mode. It replaces direct button-to-pin wiring and arbitrates three request sources: the on-board RESET/BOOT buttons, host auto-reset via the header DTR/RTS lines, and software pulses from the Avalon SPI bridge registers. It also gates the UART passthrough while the module is being reset.

---
 rtl/nina_boot_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_nina_boot_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nina_boot_sequencer.sv
// NINA ESP32 EN/GPIO0 boot sequencer: arbitrates buttons, host DTR/RTS
// and software requests into run or download-mode reset sequences.
module nina_boot_sequencer #(
   parameter int DEBOUNCE_CYCLES    = 80000,
   parameter int RESET_PULSE_CYCLES = 800000,
   parameter int BOOT_HOLD_CYCLES   = 400000,
   parameter int CNT_W              = 24
) (
   input  logic iCLK,
   input  logic iRESET,
   input  logic iRESET_BTNn,
   input  logic iBOOT_BTNn,
   input  logic iDTRn,
   input  logic iRTSn,
   input  logic iSW_RUN,
   input  logic iSW_BOOT,
   output logic oWM_RESETn,
   output logic oWM_BOOT,
   output logic oBUSY,
   output logic oMODE,
   output logic oUART_EN
);

   typedef enum logic [1:0] {
      IDLE,
      RST_ASSERT,
      HOST_RST,
      BOOT_HOLD
   } state_e;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(BOOT_HOLD_CYCLES - 1);

   // bit order: {reset button, boot button, DTR, RTS}
   logic [3:0] s1_q;
   logic [3:0] s2_q;
   logic [1:0] btn_sync;
   logic [1:0] btn_acc;
   logic       btn_prev_q;
   logic       rts_prev_q;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             mode_q, mode_d;
   logic             en_d, boot_d;
   logic             en_q, boot_q, busy_q, uart_q;

   logic host_evt;
   logic btn_evt;
   logic sw_evt;

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         s1_q       <= '1;
         s2_q       <= '1;
         btn_prev_q <= 1'b1;
         rts_prev_q <= 1'b1;
      end else begin
         s1_q       <= {iRESET_BTNn, iBOOT_BTNn, iDTRn, iRTSn};
         s2_q       <= s1_q;
         btn_prev_q <= btn_acc[1];
         rts_prev_q <= s2_q[0];
      end
   end

   assign btn_sync = s2_q[3:2];

   for (genvar g = 0; g < 2; g++) begin : g_db
      logic             acc_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge iCLK or posedge iRESET) begin
         if (iRESET) begin
            acc_q <= 1'b1;
            cnt_q <= '0;
         end else if (btn_sync[g] == acc_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            acc_q <= btn_sync[g];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign btn_acc[g] = acc_q;
   end

   assign host_evt = rts_prev_q & ~s2_q[0];
   assign btn_evt  = btn_prev_q & ~btn_acc[1];
   assign sw_evt   = iSW_RUN | iSW_BOOT;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (host_evt) begin
               state_d = HOST_RST;
               mode_d  = ~s2_q[1];
            end else if (btn_evt) begin
               state_d = RST_ASSERT;
               mode_d  = ~btn_acc[0];
            end else if (sw_evt) begin
               state_d = RST_ASSERT;
               mode_d  = iSW_BOOT;
            end
         end
         RST_ASSERT: begin
            if (timer_q == RST_LAST) begin
               state_d = mode_q ? BOOT_HOLD : IDLE;
               timer_d = '0;
            end
         end
         HOST_RST: begin
            // minimum pulse reached: hold here until the host lets RTS go
            if (timer_q == RST_LAST) begin
               timer_d = timer_q;
               if (s2_q[0]) begin
                  mode_d  = ~s2_q[1];
                  state_d = mode_d ? BOOT_HOLD : IDLE;
                  timer_d = '0;
               end
            end
         end
         BOOT_HOLD: begin
            if (timer_q == HOLD_LAST) begin
               state_d = IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      en_d   = 1'b1;
      boot_d = 1'b1;
      unique case (state_d)
         RST_ASSERT: begin
            en_d   = 1'b0;
            boot_d = ~mode_d;
         end
         HOST_RST:  en_d = 1'b0;
         BOOT_HOLD: boot_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_q <= RST_ASSERT;
         timer_q <= '0;
         mode_q  <= 1'b0;
         en_q    <= 1'b0;
         boot_q  <= 1'b1;
         busy_q  <= 1'b1;
         uart_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         mode_q  <= mode_d;
         en_q    <= en_d;
         boot_q  <= boot_d;
         busy_q  <= (state_d != IDLE);
         uart_q  <= en_d;
      end
   end

   assign oWM_RESETn = en_q;
   assign oWM_BOOT   = boot_q;
   assign oBUSY      = busy_q;
   assign oMODE      = mode_q;
   assign oUART_EN   = uart_q;

endmodule

// File: tb/tb_nina_boot_sequencer.sv
// Randomised and directed bench for nina_boot_sequencer against a
// cycle-level behavioural model of the reset/strap sequencing rules.
module tb_nina_boot_sequencer;

   localparam int DB = 4;
   localparam int RP = 10;
   localparam int BH = 6;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rbtn = 1'b1;
   logic bbtn = 1'b1;
   logic dtr  = 1'b1;
   logic rts  = 1'b1;
   logic swr  = 1'b0;
   logic swb  = 1'b0;
   logic en, boot, busy, mode, uart;

   always #5 clk = ~clk;

   nina_boot_sequencer #(
      .DEBOUNCE_CYCLES   (DB),
      .RESET_PULSE_CYCLES(RP),
      .BOOT_HOLD_CYCLES  (BH),
      .CNT_W             (24)
   ) dut (
      .iCLK       (clk),
      .iRESET     (rst),
      .iRESET_BTNn(rbtn),
      .iBOOT_BTNn (bbtn),
      .iDTRn      (dtr),
      .iRTSn      (rts),
      .iSW_RUN    (swr),
      .iSW_BOOT   (swb),
      .oWM_RESETn (en),
      .oWM_BOOT   (boot),
      .oBUSY      (busy),
      .oMODE      (mode),
      .oUART_EN   (uart)
   );

   int checks = 0;
   int errs   = 0;

   typedef enum {P_IDLE, P_PULSE, P_HOST, P_HOLD} phase_e;
   phase_e ph;
   int     n;
   bit     m_mode;
   logic [3:0] pipe0, pipe1;
   bit     acc [2];
   int     run [2];
   bit     btn_prev, rts_prev;

   int en_run = 0, last_en_low = 0, seq_cnt = 0;
   int hold_run = 0, last_hold = 0, hold_cnt = 0;

   function automatic void m_reset();
      ph = P_PULSE;
      n = 0;
      m_mode = 1'b0;
      pipe0 = '1;
      pipe1 = '1;
      acc[0] = 1'b1;
      acc[1] = 1'b1;
      run[0] = 0;
      run[1] = 0;
      btn_prev = 1'b1;
      rts_prev = 1'b1;
   endfunction

   function automatic void m_step();
      logic [3:0] s = pipe1;
      bit host  = rts_prev && !s[0];
      bit press = btn_prev && !acc[1];
      case (ph)
         P_IDLE: begin
            if (host) begin
               ph = P_HOST; n = 0; m_mode = !s[1];
            end else if (press) begin
               ph = P_PULSE; n = 0; m_mode = !acc[0];
            end else if (swr || swb) begin
               ph = P_PULSE; n = 0; m_mode = swb;
            end
         end
         P_PULSE: begin
            n++;
            if (n == RP) begin
               ph = m_mode ? P_HOLD : P_IDLE; n = 0;
            end
         end
         P_HOST: begin
            if (n >= RP - 1 && s[0]) begin
               m_mode = !s[1];
               ph = m_mode ? P_HOLD : P_IDLE; n = 0;
            end else n++;
         end
         P_HOLD: begin
            n++;
            if (n == BH) begin
               ph = P_IDLE; n = 0;
            end
         end
      endcase
      btn_prev = acc[1];
      rts_prev = s[0];
      for (int i = 0; i < 2; i++) begin
         bit lvl = s[2+i];
         if (lvl != acc[i]) begin
            run[i]++;
            if (run[i] == DB) begin
               acc[i] = lvl; run[i] = 0;
            end
         end else run[i] = 0;
      end
      pipe1 = pipe0;
      pipe0 = {rbtn, bbtn, dtr, rts};
   endfunction

   function automatic void cmp(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void lit(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_outputs();
      bit e_en = !(ph == P_PULSE || ph == P_HOST);
      bit e_bt = (ph == P_HOLD) ? 1'b0 : (ph == P_PULSE) ? !m_mode : 1'b1;
      cmp("en", en, e_en);
      cmp("boot", boot, e_bt);
      cmp("busy", busy, ph != P_IDLE);
      cmp("mode", mode, m_mode);
      cmp("uart", uart, e_en);
   endfunction

   function automatic void track();
      if (!en && !rst) en_run++;
      else begin
         if (en_run > 0) begin
            last_en_low = en_run; seq_cnt++;
         end
         en_run = 0;
      end
      if (en && !boot) hold_run++;
      else begin
         if (hold_run > 0) begin
            last_hold = hold_run; hold_cnt++;
         end
         hold_run = 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) m_reset();
      else m_step();
      @(negedge clk);
      check_outputs();
      track();
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic en_low_after_release(input string name);
      int k = 0;
      rst = 1'b0;
      while (!en && k < 50) begin
         tick();
         k++;
      end
      lit(name, k, RP);
   endtask

   initial begin
      int base;
      m_reset();
      ticks(3);

      en_low_after_release("t1_por_len");
      lit("t1_busy", busy, 0);
      lit("t1_boot", boot, 1);
      lit("t1_mode", mode, 0);
      ticks(10);

      base = seq_cnt;
      rbtn = 0; ticks(3); rbtn = 1; ticks(2);
      rbtn = 0; ticks(3); rbtn = 1; ticks(1);
      rbtn = 0; ticks(20); rbtn = 1; ticks(20);
      lit("t2_one_seq", seq_cnt, base + 1);
      lit("t2_len", last_en_low, RP);
      lit("t2_mode", mode, 0);
      rbtn = 0; ticks(3); rbtn = 1; ticks(20);
      lit("t2_short", seq_cnt, base + 1);

      bbtn = 0; ticks(8); rbtn = 0; ticks(8);
      rbtn = 1; bbtn = 1; ticks(30);
      lit("t3_len", last_en_low, RP);
      lit("t3_hold", last_hold, BH);
      lit("t3_mode", mode, 1);

      base = hold_cnt;
      rts = 0; ticks(3); rts = 1; dtr = 0; ticks(30); dtr = 1; ticks(5);
      lit("t4a_len", last_en_low, RP);
      lit("t4a_hold", last_hold, BH);
      lit("t4a_holds", hold_cnt, base + 1);
      lit("t4a_mode", mode, 1);
      base = hold_cnt;
      rts = 0; ticks(3); rts = 1; ticks(30);
      lit("t4b_len", last_en_low, RP);
      lit("t4b_holds", hold_cnt, base);
      lit("t4b_mode", mode, 0);

      rts = 0; ticks(2);
      swr = 1; swb = 1; tick(); swr = 0; swb = 0;
      lit("t5_en", en, 0);
      lit("t5_boot", boot, 1);
      lit("t5_mode", mode, 0);
      ticks(3);
      swb = 1; tick(); swb = 0;
      lit("t5_mode_kept", mode, 0);
      lit("t5_boot_kept", boot, 1);
      rts = 1; ticks(25);
      lit("t5_idle", busy, 0);

      swb = 1; tick(); swb = 0; ticks(12);
      lit("t6_in_hold", {en, boot}, 2'b10);
      rst = 1; #1;
      m_reset();
      check_outputs();
      lit("t6_rst_vals", {en, boot, busy, mode, uart}, 5'b01100);
      ticks(2);
      en_low_after_release("t6_len");
      lit("t6_mode", mode, 0);
      lit("t6_boot", boot, 1);
      ticks(5);

      for (int c = 0; c < 3000; c++) begin
         int r;
         swr = 0;
         swb = 0;
         if (rst) rst = 0;
         r = int'($urandom_range(0, 99));
         if (r < 3) rbtn = !rbtn;
         else if (r < 5) bbtn = !bbtn;
         else if (r < 7) rts = !rts;
         else if (r < 9) dtr = !dtr;
         else if (r == 9) swr = 1;
         else if (r == 10) swb = 1;
         else if (r == 11 && $urandom_range(0, 19) == 0) begin
            rst = 1; #1;
            m_reset();
            check_outputs();
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
